// File: rtl/banked_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banked_ram_ctrl_pkg
// Description : Shared constants and types for the banked RAM controller.
//               Holds the default geometry (data width, address width,
//               bank-select bits) and the controller FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package banked_ram_ctrl_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 10;
    localparam int BANK_BITS_DEF = 2;

    // CLEAR zero-fills every bank after reset; RUN serves host accesses.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage : banked_ram_ctrl_pkg
`default_nettype wire

// File: rtl/banked_ram_ctrl_ram_bank.sv
`default_nettype none
// ============================================================================
// Module      : ram_bank
// Description : One synchronous RAM bank with a byte-enabled write port and
//               a registered read port. Storage itself is never reset.
// Ports       : clk       - clock
//               rst_n     - async active-low reset (read register only)
//               we_i      - write strobe
//               re_i      - read strobe, loads rdata_o at the clock edge
//               addr_i    - row address
//               wdata_i   - write data
//               be_i      - byte enables for writes
//               rdata_o   - registered read data, holds between reads
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bank
    import banked_ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROW_W  = ADDR_W_DEF - BANK_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ROW_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int NBYTE = DATA_W / 8;
    localparam int DEPTH = 2 ** ROW_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : ram_bank
`default_nettype wire

// File: rtl/banked_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : banked_ram_ctrl
// Description : Banked single-port RAM controller. After reset it walks a row
//               counter through every row, zeroing that row in all banks at
//               once, then accepts one read or write per cycle.
// Ports       : clk     - clock
//               rst_n   - async active-low reset
//               cs      - active-low chip select
//               rw      - 1 = write, 0 = read
//               addr    - word address (MSBs = bank, LSBs = row)
//               wdata   - write data
//               be      - write byte enables
//               rdata   - registered read data
//               rvalid  - one-cycle pulse with new rdata
//               ready   - accesses accepted
// Revision    : 1.0 - initial release
// ============================================================================
module banked_ram_ctrl
    import banked_ram_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BANK_BITS = BANK_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  rw,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  ready
);

    localparam int ROW_W = ADDR_W - BANK_BITS;
    localparam int NBANK = 2 ** BANK_BITS;
    localparam int NBYTE = DATA_W / 8;

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      clr_row_q, clr_row_d;
    logic                  rvalid_q, rvalid_d;
    logic [BANK_BITS-1:0]  rd_bank_q, rd_bank_d;

    logic                  clearing;
    logic                  accept;
    logic [BANK_BITS-1:0]  bank_sel;
    logic [ROW_W-1:0]      row_sel;
    logic [DATA_W-1:0]     bank_rdata [NBANK];

    assign bank_sel = addr[ADDR_W-1 -: BANK_BITS];
    assign row_sel  = addr[ROW_W-1:0];
    assign accept   = ready & ~cs;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // The last row is cleared on the edge that also moves us to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (&clr_row_q) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready    = 1'b0;
        clearing = 1'b0;
        case (state_q)
            ST_CLEAR: clearing = 1'b1;
            ST_RUN:   ready    = 1'b1;
            default:  clearing = 1'b1;
        endcase
    end

    // ---------------- clear counter and read tracking ----------------
    always_comb begin
        clr_row_d = clearing ? clr_row_q + 1'b1 : clr_row_q;
        rvalid_d  = accept & ~rw;
        // Remember which bank answered so the mux keeps pointing at it
        // until the next accepted read.
        rd_bank_d = (accept & ~rw) ? bank_sel : rd_bank_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_row_q <= '0;
            rvalid_q  <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            clr_row_q <= clr_row_d;
            rvalid_q  <= rvalid_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // ---------------- banks ----------------
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic               bank_hit;
        logic               bank_we;
        logic               bank_re;
        logic [ROW_W-1:0]   bank_addr;
        logic [DATA_W-1:0]  bank_wdata;
        logic [NBYTE-1:0]   bank_be;

        assign bank_hit   = (bank_sel == BANK_BITS'(b));
        // During CLEAR every bank writes zero to the counter row.
        assign bank_we    = clearing | (accept & rw & bank_hit);
        assign bank_re    = accept & ~rw & bank_hit;
        assign bank_addr  = clearing ? clr_row_q : row_sel;
        assign bank_wdata = clearing ? '0 : wdata;
        assign bank_be    = clearing ? '1 : be;

        ram_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_ram_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (bank_we),
            .re_i    (bank_re),
            .addr_i  (bank_addr),
            .wdata_i (bank_wdata),
            .be_i    (bank_be),
            .rdata_o (bank_rdata[b])
        );
    end

    assign rdata  = bank_rdata[rd_bank_q];
    assign rvalid = rvalid_q;

endmodule : banked_ram_ctrl
`default_nettype wire

// File: doc/banked_ram_ctrl.md
BANKED_RAM_CTRL -- requirements
Module: banked_ram_ctrl

Interface
REQ-001 Parameter DATA_W, 16, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, 10, total word-address width.
REQ-003 Parameter BANK_BITS, 2, number of address MSBs that select a bank (NBANK = 2**BANK_BITS).
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port cs  input  1  chip select, active-low; an access is accepted only when cs=0 and ready=1.
REQ-007 Port rw  input  1  1 = write, 0 = read.
REQ-008 Port addr  input  ADDR_W  word address; addr[ADDR_W-1 -: BANK_BITS] selects the bank, the low bits select the row.
REQ-009 Port wdata  input  DATA_W  write data.
REQ-010 Port be  input  DATA_W/8  byte enables for writes; ignored for reads.
REQ-011 Port rdata  output  DATA_W  read data, registered.
REQ-012 Port rvalid  output  1  one-cycle pulse marking new rdata.
REQ-013 Port ready  output  1  high when accesses are accepted (RUN state).

Function
REQ-014 FSM states SHALL be CLEAR and RUN only.
REQ-015 On reset the FSM SHALL enter CLEAR.
REQ-016 In CLEAR, a row counter SHALL advance 0..BANK_DEPTH-1, one row per cycle, with BANK_DEPTH = 2**(ADDR_W-BANK_BITS).
REQ-017 In CLEAR, the current row SHALL be written to zero in all banks in the same cycle.
REQ-018 CLEAR SHALL last exactly BANK_DEPTH cycles, then go to RUN; ready SHALL rise in the cycle after the last row is cleared.
REQ-019 In CLEAR, ready=0 and all cs/rw/addr/wdata/be inputs SHALL be ignored.
REQ-020 In RUN, an accepted write SHALL update only the bytes with be[i]=1 in the addressed bank/row at that clock edge; no rvalid SHALL be produced.
REQ-021 In RUN, an accepted read SHALL set rdata to the addressed word and pulse rvalid for exactly one cycle, at the edge after acceptance (latency 1).
REQ-022 rdata SHALL hold its value until the next accepted read.
REQ-023 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-024 When cs=1, memory and rdata SHALL be unchanged and rvalid=0.
REQ-025 Back-to-back accesses SHALL be accepted every cycle with no bubbles; any read/write sequence is legal.
REQ-026 Only one bank SHALL be accessed per RUN cycle; all other banks SHALL hold.
REQ-027 Addresses SHALL NOT wrap: every ADDR_W-bit value maps to exactly one bank/row.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set rdata=0, rvalid=0, ready=0, clear row counter=0 and FSM=CLEAR.
REQ-029 rst_n asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from row 0.
REQ-030 Memory arrays themselves SHALL have no reset; zero contents come only from CLEAR.
REQ-031 Deassertion of rst_n SHALL take effect at the first clk edge after release; CLEAR begins on that edge.

Structure
REQ-032 A shared package SHALL hold the DATA_W/ADDR_W/BANK_BITS default constants and the FSM state typedef.
REQ-033 One sub-module, ram_bank, SHALL implement one synchronous bank with a byte-enabled write port and a registered read port.
REQ-034 banked_ram_ctrl SHALL instantiate NBANK ram_bank copies via generate, and hold the FSM, the clear counter and the read-data mux.
REQ-035 The read-data mux SHALL select on the registered bank index of the read.

Verification
REQ-036 Reset, hold rst_n=1 -> ready=0 for exactly 256 cycles (default params), then 1; a read of every address returns 0.
REQ-037 Write 168 to addr 7 and 44 to addr 1000 (be=2'b11), then read 19, 7, 1000 back-to-back -> rdata 0, 168, 44 on consecutive cycles, each with a one-cycle rvalid pulse.
REQ-038 Write 16'hABCD to addr 400, then write 16'h1200 with be=2'b10 -> read of 400 returns 16'h12CD.
REQ-039 Write 77 to addr 700 and read 700 in the next cycle -> rdata=77; apply cs=1 with rw=1, addr=700, wdata=5 -> read of 700 still returns 77 and rvalid stays 0 while cs=1.
REQ-040 Pull rst_n low mid-RUN after writing 168 to addr 7 -> outputs zero at once, CLEAR reruns, and a later read of addr 7 returns 0.
REQ-041 Parameter sweep DATA_W=32, ADDR_W=12, BANK_BITS=3 -> CLEAR lasts 512 cycles; write/read of address 4095 with be=4'b0101 returns only bytes 0 and 2, other bytes 0.
